// File: rtl/hps_connection.sv
// File-access bridge stand-in: zero-terminated name stream opens or creates a named
// slot in on-chip RAM, then serves word reads/writes and delete against that slot.
module hps_connection #(
    parameter int FILES    = 4,
    parameter int WORDS    = 256,
    parameter int NAME_LEN = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [31:0] name_stream_export,
    input  logic        read_enable_export,
    input  logic        write_enable_export,
    input  logic        delete_file_export,
    input  logic [31:0] address_export,
    input  logic [31:0] write_data_export,
    output logic [31:0] read_data_export,
    output logic        file_open_export
);

    localparam int SW = (FILES > 1) ? $clog2(FILES) : 1;
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int LW = $clog2(NAME_LEN + 1);
    localparam int IW = (NAME_LEN > 1) ? $clog2(NAME_LEN) : 1;

    typedef logic [NAME_LEN-1:0][7:0] name_t;

    logic [31:0]      mem        [FILES][WORDS];
    logic [WORDS-1:0] word_valid [FILES];
    name_t            slot_name  [FILES];
    logic [LW-1:0]    slot_len   [FILES];
    logic [FILES-1:0] slot_used;
    name_t            acc_name;
    logic [LW-1:0]    acc_len;
    logic [SW-1:0]    cur_slot;

    name_t            acc_n;
    logic [LW-1:0]    len_n;
    logic             term;
    logic [7:0]       byte_v;
    logic             found;
    logic             alloc;
    logic [SW-1:0]    alloc_slot;
    logic [SW-1:0]    cur_n;
    logic             open_n;
    logic [FILES-1:0] used_n;
    logic             in_range;
    logic [AW-1:0]    widx;
    logic             rd_ok;
    logic             wr_ok;

    // Bytes past NAME_LEN are dropped, and unused accumulator bytes stay zero, so
    // names can be compared as whole vectors plus length.
    always_comb begin
        acc_n  = acc_name;
        len_n  = acc_len;
        term   = 1'b0;
        byte_v = '0;
        for (int b = 0; b < 4; b++) begin
            byte_v = name_stream_export[31-8*b -: 8];
            if (!term) begin
                if (byte_v == 8'd0) begin
                    term = 1'b1;
                end else if (len_n < LW'(NAME_LEN)) begin
                    acc_n[len_n[IW-1:0]] = byte_v;
                    len_n = len_n + LW'(1);
                end
            end
        end
    end

    always_comb begin
        found      = 1'b0;
        alloc      = 1'b0;
        alloc_slot = '0;
        cur_n      = cur_slot;
        open_n     = file_open_export;
        used_n     = slot_used;
        if (term && (len_n != '0)) begin
            for (int i = 0; i < FILES; i++) begin
                if (!found && slot_used[i] && (slot_len[i] == len_n) && (slot_name[i] == acc_n)) begin
                    found = 1'b1;
                    cur_n = SW'(i);
                end
            end
            if (!found) begin
                for (int i = 0; i < FILES; i++) begin
                    if (!alloc && !slot_used[i]) begin
                        alloc      = 1'b1;
                        alloc_slot = SW'(i);
                    end
                end
            end
            open_n = found | alloc;
            if (alloc) begin
                cur_n          = alloc_slot;
                used_n[alloc_slot] = 1'b1;
            end
        end
        if (delete_file_export && open_n) begin
            used_n[cur_n] = 1'b0;
            open_n        = 1'b0;
        end
        in_range = address_export < 32'(WORDS);
        widx     = address_export[AW-1:0];
        // A slot allocated this cycle still holds stale valid bits until the edge.
        rd_ok    = open_n && in_range && !alloc && word_valid[cur_n][widx];
        wr_ok    = write_enable_export && open_n && in_range;
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            slot_used        <= '0;
            acc_name         <= '0;
            acc_len          <= '0;
            cur_slot         <= '0;
            file_open_export <= 1'b0;
            read_data_export <= '0;
            for (int i = 0; i < FILES; i++) begin
                word_valid[i] <= '0;
                slot_name[i]  <= '0;
                slot_len[i]   <= '0;
            end
        end else begin
            slot_used        <= used_n;
            file_open_export <= open_n;
            cur_slot         <= cur_n;
            if (term) begin
                acc_name <= '0;
                acc_len  <= '0;
            end else begin
                acc_name <= acc_n;
                acc_len  <= len_n;
            end
            if (alloc) begin
                slot_name[alloc_slot]  <= acc_n;
                slot_len[alloc_slot]   <= len_n;
                word_valid[alloc_slot] <= '0;
            end
            if (wr_ok) begin
                word_valid[cur_n][widx] <= 1'b1;
            end
            if (delete_file_export) begin
                read_data_export <= '0;
            end else if (read_enable_export) begin
                read_data_export <= rd_ok ? mem[cur_n][widx] : '0;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset_n && wr_ok) begin
            mem[cur_n][widx] <= write_data_export;
        end
    end

endmodule

// File: tb/tb_hps_connection.sv
// Directed bench for hps_connection: a vector table of one-cycle operations with
// hand-computed read data and open flag, plus reset and long-name sequences.
module tb_hps_connection;

    logic        clk_clk;
    logic        reset_reset_n;
    logic [31:0] name_stream_export;
    logic        read_enable_export;
    logic        write_enable_export;
    logic        delete_file_export;
    logic [31:0] address_export;
    logic [31:0] write_data_export;
    logic [31:0] read_data_export;
    logic        file_open_export;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] name;
        logic        rd;
        logic        wr;
        logic        del;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_open;
    } vec_t;

    vec_t vecs[$];

    hps_connection dut (
        .clk_clk             (clk_clk),
        .reset_reset_n       (reset_reset_n),
        .name_stream_export  (name_stream_export),
        .read_enable_export  (read_enable_export),
        .write_enable_export (write_enable_export),
        .delete_file_export  (delete_file_export),
        .address_export      (address_export),
        .write_data_export   (write_data_export),
        .read_data_export    (read_data_export),
        .file_open_export    (file_open_export)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    function automatic void add(input logic [31:0] n, input logic r, input logic w, input logic d,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] er, input logic eo);
        vecs.push_back('{n, r, w, d, a, wd, er, eo});
    endfunction

    // Drive one cycle of inputs, then check outputs #1 after the edge.
    task automatic step(input string tag, input logic [31:0] n, input logic r, input logic w,
                        input logic d, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic eo);
        name_stream_export  = n;
        read_enable_export  = r;
        write_enable_export = w;
        delete_file_export  = d;
        address_export      = a;
        write_data_export   = wd;
        @(posedge clk_clk);
        #1;
        checks++;
        if (read_data_export !== er) begin
            errors++;
            $display("FAIL %s read_data got %h expected %h", tag, read_data_export, er);
        end
        checks++;
        if (file_open_export !== eo) begin
            errors++;
            $display("FAIL %s file_open got %b expected %b", tag, file_open_export, eo);
        end
    endtask

    initial begin
        reset_reset_n       = 1'b0;
        name_stream_export  = '0;
        read_enable_export  = 1'b0;
        write_enable_export = 1'b0;
        delete_file_export  = 1'b0;
        address_export      = '0;
        write_data_export   = '0;

        //   name          rd wr del addr  wdata         exp_rd        open
        add(32'h41420000, 0, 0, 0, 0,    0,            32'h0,        1); // 0 open AB (slot0)
        add(32'h0,        1, 0, 0, 5,    0,            32'h0,        1); // 1 unwritten word
        add(32'h0,        0, 1, 0, 3,    32'hDEADBEEF, 32'h0,        1); // 2
        add(32'h0,        1, 0, 0, 3,    0,            32'hDEADBEEF, 1); // 3
        add(32'h0,        1, 1, 0, 3,    32'h12345678, 32'hDEADBEEF, 1); // 4 read-before-write
        add(32'h0,        1, 0, 0, 3,    0,            32'h12345678, 1); // 5
        add(32'h66696C65, 0, 0, 0, 0,    0,            32'h12345678, 1); // 6 "file" partial
        add(32'h31000000, 0, 0, 0, 0,    0,            32'h12345678, 1); // 7 "file1" slot1
        add(32'h0,        1, 0, 0, 3,    0,            32'h0,        1); // 8
        add(32'h41420000, 1, 0, 0, 3,    0,            32'h12345678, 1); // 9 reopen AB + read
        add(32'h66696C65, 0, 0, 0, 0,    0,            32'h12345678, 1); // 10
        add(32'h31000000, 1, 0, 0, 3,    0,            32'h0,        1); // 11 reopen file1 + read
        add(32'h41420000, 1, 0, 0, 3,    0,            32'h12345678, 1); // 12
        add(32'h0,        0, 0, 1, 0,    0,            32'h0,        0); // 13 delete AB
        add(32'h0,        1, 1, 0, 3,    32'hAAAA5555, 32'h0,        0); // 14 no file open
        add(32'h41420000, 0, 0, 0, 0,    0,            32'h0,        1); // 15 AB recreated slot0
        add(32'h0,        1, 0, 0, 3,    0,            32'h0,        1); // 16
        add(32'h0,        0, 1, 0, 256,  32'h00000055, 32'h0,        1); // 17 out of range write
        add(32'h0,        1, 0, 0, 0,    0,            32'h0,        1); // 18 no wrap to word 0
        add(32'h0,        1, 0, 0, 256,  0,            32'h0,        1); // 19
        add(32'h0,        0, 1, 0, 255,  32'hCAFEF00D, 32'h0,        1); // 20 last word
        add(32'h0,        1, 0, 0, 255,  0,            32'hCAFEF00D, 1); // 21 idle keeps open
        add(32'h43000000, 0, 0, 0, 0,    0,            32'hCAFEF00D, 1); // 22 "C" slot2
        add(32'h0,        0, 1, 0, 3,    32'h11111111, 32'hCAFEF00D, 1); // 23
        add(32'h44000000, 0, 0, 0, 0,    0,            32'hCAFEF00D, 1); // 24 "D" slot3
        add(32'h45000000, 0, 0, 0, 0,    0,            32'hCAFEF00D, 0); // 25 "E" no slot free
        add(32'h0,        1, 0, 0, 3,    0,            32'h0,        0); // 26
        add(32'h43000000, 0, 0, 0, 0,    0,            32'h0,        1); // 27 reopen C
        add(32'h0,        1, 0, 0, 3,    0,            32'h11111111, 1); // 28
        add(32'h0,        0, 0, 1, 0,    0,            32'h0,        0); // 29 delete C
        add(32'h45000000, 0, 0, 0, 0,    0,            32'h0,        1); // 30 "E" takes slot2
        add(32'h0,        1, 0, 0, 3,    0,            32'h0,        1); // 31 fresh slot
        add(32'h41420000, 1, 0, 0, 255,  0,            32'hCAFEF00D, 1); // 32 AB retained

        step("reset0", 32'h0, 0, 0, 0, 0, 0, 32'h0, 0);
        step("reset1", 32'h0, 0, 0, 0, 0, 0, 32'h0, 0);
        reset_reset_n = 1'b1;

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].del,
                 vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_open);
        end

        // Reset mid-name: the "file" prefix must be discarded, so "1" and "file1" differ.
        step("mid_pre",   32'h66696C65, 0, 0, 0, 0, 0, 32'hCAFEF00D, 1);
        reset_reset_n = 1'b0;
        step("mid_rst",   32'h0,        0, 0, 0, 0, 0, 32'h0, 0);
        reset_reset_n = 1'b1;
        step("mid_one",   32'h31000000, 0, 0, 0, 0, 0, 32'h0, 1);
        step("mid_wr",    32'h0,        0, 1, 0, 7, 32'h00000077, 32'h0, 1);
        step("mid_f",     32'h66696C65, 0, 0, 0, 0, 0, 32'h0, 1);
        step("mid_f1",    32'h31000000, 0, 0, 0, 0, 0, 32'h0, 1);
        step("mid_rd",    32'h0,        1, 0, 0, 7, 0, 32'h0, 1);

        // Names longer than NAME_LEN compare on their first 16 bytes only.
        step("long_a0",   32'h41424344, 0, 0, 0, 0, 0, 32'h0, 1);
        step("long_a1",   32'h45464748, 0, 0, 0, 0, 0, 32'h0, 1);
        step("long_a2",   32'h494A4B4C, 0, 0, 0, 0, 0, 32'h0, 1);
        step("long_a3",   32'h4D4E4F50, 0, 0, 0, 0, 0, 32'h0, 1);
        step("long_a4",   32'h51520000, 0, 0, 0, 0, 0, 32'h0, 1);
        step("long_wr",   32'h0,        0, 1, 0, 1, 32'h00000099, 32'h0, 1);
        step("long_b0",   32'h41424344, 0, 0, 0, 0, 0, 32'h0, 1);
        step("long_b1",   32'h45464748, 0, 0, 0, 0, 0, 32'h0, 1);
        step("long_b2",   32'h494A4B4C, 0, 0, 0, 0, 0, 32'h0, 1);
        step("long_b3",   32'h4D4E4F50, 0, 0, 0, 0, 0, 32'h0, 1);
        step("long_term", 32'h0,        1, 0, 0, 1, 0, 32'h00000099, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hps_connection.md
Name: hps_connection

Overview:
- Single-clock, synthesizable stand-in for the HPS file-access bridge.
- Filenames arrive as a zero-terminated byte stream; the block opens, or creates, a named file held in on-chip RAM slots.
- While a file is open, it serves 32-bit word reads and writes at word addresses, and it can delete the open file.
- It sits between the CPU-side filesystem wrapper and storage. Its clock comes from the upstream pll_clock, which is not part of this block.

Parameters:
- FILES, 4, number of file slots.
- WORDS, 256, 32-bit words per file; must be a power of two.
- NAME_LEN, 16, maximum stored filename bytes.

Ports:
- clk_clk  input  1  system clock; all logic on its rising edge.
- reset_reset_n  input  1  reset, synchronous, active-low.
- name_stream_export  input  32  filename bytes, MSB byte first: [31:24], [23:16], [15:8], [7:0].
- read_enable_export  input  1  read request.
- write_enable_export  input  1  write request.
- delete_file_export  input  1  delete the open file.
- address_export  input  32  word address within the open file.
- write_data_export  input  32  write data.
- read_data_export  output  32  registered read data.
- file_open_export  output  1  a file is currently open.

Behaviour:
- Reset, sampled on clk_clk when reset_reset_n=0:
  - all slots free, name accumulator empty, no file open;
  - read_data_export=0, file_open_export=0.
- Name stream, each cycle:
  - Scan the 4 bytes MSB to LSB.
  - Each nonzero byte is appended to the accumulator. Bytes beyond NAME_LEN are dropped, so comparison uses only the first NAME_LEN bytes.
  - The first zero byte terminates the scan; later bytes in that word are ignored.
  - On termination with accumulator length > 0, open that name, then clear the accumulator.
  - On termination with an empty accumulator (e.g. an all-zero word), nothing happens; the current file stays open. This is the idle condition.
  - If all four bytes are nonzero, accumulation continues next cycle.
- Open:
  - Compare the full name and length against all used slots.
  - On a match, that slot becomes current and its contents are preserved.
  - Otherwise allocate the lowest-index free slot, store the name, and mark every word of the slot unwritten (per-word valid bits cleared).
  - If no slot is free, no file is open and file_open_export=0.
  - Opening a name always closes the previous file; the previous slot's data is retained.
- Same-cycle priority, one cycle evaluated in order:
  1. name processing;
  2. delete;
  3. read/write against the file open after steps 1–2.
- Delete: if a file is open, free its slot (name invalid), close it, and set read_data_export=0. Delete with no file open is a no-op apart from read_data_export=0.
- Reads:
  - When a file is open and read_enable_export=1, read_data_export gets the word at address_export on the next edge (1-cycle latency).
  - Unwritten words, address >= WORDS, or no file open all return 0.
  - When read_enable_export=0, read_data_export holds its value.
- Writes:
  - When a file is open and write_enable_export=1 with address < WORDS, store write_data_export and set the word's valid bit.
  - Writes with address >= WORDS or no file open are ignored.
- Simultaneous read and write to the same address: the read returns the old value (read-before-write); the new value is visible from the next read.
- No byte swapping: data reads back exactly as written.
- Reset mid-stream discards the partial name and all file contents.

Test Plan:
- Reset, then name_stream_export=0x41420000 ("AB" plus terminator) → file_open_export=1 next cycle. Then read address 5 → read_data_export=0 one cycle later.
- With "AB" open: write 0xDEADBEEF at address 3, then read 3 → 0xDEADBEEF. Simultaneous read+write of 0x12345678 at 3 → 0xDEADBEEF returned; the next read returns 0x12345678.
- Streaming names:
  - Stream 0x66696C65 then 0x31000000 ("file1") → opens a new slot.
  - Reopen "AB" → address 3 still reads 0x12345678.
  - Reopen "file1" → address 3 reads 0.
- Delete "AB" (delete_file_export=1) → file_open_export=0, read_data_export=0. Reopen "AB" → address 3 reads 0. Read or write with no file open → reads 0, writes ignored.
- Slot exhaustion (FILES=4): open 4 distinct names, then a 5th → file_open_export=0. Delete one, then open the 5th → succeeds.
- Boundary and idle:
  - Write at address WORDS → ignored, reads 0.
  - An all-zero name_stream word while a file is open leaves it open.
  - Name word terminator plus read in the same cycle → the read targets the newly opened file.
